// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults and width helper for the router synchroniser
package router_pkg;

    localparam int ROUTER_NUM_CH  = 3;
    localparam int ROUTER_ADDR_W  = 2;
    localparam int ROUTER_TIMEOUT = 30;

    // Smallest counter width able to hold TIMEOUT-1.
    function automatic int router_cnt_w(input int timeout);
        int w;
        w = 1;
        while ((1 << w) <= timeout - 1) w++;
        return w;
    endfunction

endpackage

// File: rtl/router_sync_timer.sv
// rtl/router_sync_timer.sv - per-channel stall timer with soft-reset pulse and sticky status
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int CNT_W   = router_cnt_w(TIMEOUT)
) (
    input  logic clk,
    input  logic reset,
    input  logic stall,
    input  logic sts_clr,
    output logic soft_reset,
    output logic timeout_sts
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             fire;

    assign fire = stall && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            soft_reset  <= 1'b0;
            timeout_sts <= 1'b0;
        end else begin
            soft_reset <= fire;
            if (!stall || fire) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A new timeout wins over a simultaneous clear.
            if (fire) begin
                timeout_sts <= 1'b1;
            end else if (sts_clr) begin
                timeout_sts <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/router_sync_param.sv
// rtl/router_sync_param.sv - parametrised router synchroniser: address steering, valid-out, stall timeouts
module router_sync_param
    import router_pkg::*;
#(
    parameter int NUM_CH  = ROUTER_NUM_CH,
    parameter int ADDR_W  = ROUTER_ADDR_W,
    parameter int TIMEOUT = ROUTER_TIMEOUT,
    parameter int CNT_W   = router_cnt_w(TIMEOUT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic              sts_clr,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err,
    output logic [NUM_CH-1:0] timeout_sts
);

    localparam logic [ADDR_W:0] NUM_CH_X = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] dest;

    always_ff @(posedge clk) begin
        if (reset) begin
            dest <= '0;
        end else if (detect_add) begin
            dest <= addr_in;
        end
    end

    assign addr_err = !({1'b0, dest} < NUM_CH_X);
    assign vld_out  = ~empty;

    // An out-of-range dest matches no channel, so both outputs fall to zero.
    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (dest == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_timer
        router_sync_timer #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_timer (
            .clk         (clk),
            .reset       (reset),
            .stall       (vld_out[g] && !read_enb[g]),
            .sts_clr     (sts_clr),
            .soft_reset  (soft_reset[g]),
            .timeout_sts (timeout_sts[g])
        );
    end

endmodule

// File: tb/tb_router_sync_param.sv
// tb/tb_router_sync_param.sv - randomized and directed bench for router_sync_param (3ch/30 and 8ch/5)
module tb_router_sync_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, detect_add, write_enb_reg, sts_clr;
    logic [2:0] addr_in;
    logic [7:0] read_enb, empty, full;

    logic [2:0] vld_a, we_a, sr_a, sts_a;
    logic       ff_a, err_a;
    logic [7:0] vld_b, we_b, sr_b, sts_b;
    logic       ff_b, err_b;

    int compared   = 0;
    int mismatched = 0;

    router_sync_param dut_a (
        .clk(clk), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
        .addr_in(addr_in[1:0]), .read_enb(read_enb[2:0]), .empty(empty[2:0]), .full(full[2:0]),
        .sts_clr(sts_clr), .vld_out(vld_a), .write_enb(we_a), .fifo_full(ff_a),
        .soft_reset(sr_a), .addr_err(err_a), .timeout_sts(sts_a)
    );

    router_sync_param #(.NUM_CH(8), .ADDR_W(3), .TIMEOUT(5)) dut_b (
        .clk(clk), .reset(reset), .detect_add(detect_add), .write_enb_reg(write_enb_reg),
        .addr_in(addr_in), .read_enb(read_enb), .empty(empty), .full(full),
        .sts_clr(sts_clr), .vld_out(vld_b), .write_enb(we_b), .fifo_full(ff_b),
        .soft_reset(sr_b), .addr_err(err_b), .timeout_sts(sts_b)
    );

    // Reference model: per instance, destination and length of the current stall run.
    int m_dest [2];
    int run    [2][8];
    bit m_sr   [2][8];
    bit m_sts  [2][8];

    function automatic int nch(input int k);   return (k == 0) ? 3 : 8;  endfunction
    function automatic int tmo(input int k);   return (k == 0) ? 30 : 5; endfunction
    function automatic int amask(input int k); return (k == 0) ? 3 : 7;  endfunction

    task automatic model_edge();
        bit stall;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_dest[k] = 0;
                for (int c = 0; c < 8; c++) begin
                    run[k][c] = 0; m_sr[k][c] = 0; m_sts[k][c] = 0;
                end
            end else begin
                if (detect_add) m_dest[k] = int'(addr_in) & amask(k);
                for (int c = 0; c < nch(k); c++) begin
                    stall = !empty[c] && !read_enb[c];
                    run[k][c] = stall ? run[k][c] + 1 : 0;
                    m_sr[k][c] = stall && (run[k][c] % tmo(k) == 0);
                    if (m_sr[k][c]) m_sts[k][c] = 1;
                    else if (sts_clr) m_sts[k][c] = 0;
                end
            end
        end
    endtask

    function automatic logic [33:0] exp_vec(input int k);
        logic [7:0] v, we, sr, st;
        logic ff, err;
        v = '0; we = '0; sr = '0; st = '0;
        for (int c = 0; c < nch(k); c++) begin
            v[c] = !empty[c]; sr[c] = m_sr[k][c]; st[c] = m_sts[k][c];
        end
        err = (m_dest[k] >= nch(k));
        ff  = !err && full[m_dest[k]];
        if (!err && write_enb_reg) we[m_dest[k]] = 1'b1;
        return {v, we, ff, sr, err, st};
    endfunction

    function automatic logic [33:0] act_vec(input int k);
        if (k == 0) return {5'b0, vld_a, 5'b0, we_a, ff_a, 5'b0, sr_a, err_a, 5'b0, sts_a};
        return {vld_b, we_b, ff_b, sr_b, err_b, sts_b};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        reset = 0; detect_add = 0; write_enb_reg = 0; addr_in = '0;
        read_enb = '0; empty = 8'hff; full = '0; sts_clr = 1;
        step();
        sts_clr = 0;
    endtask

    task automatic test_reset();
        reset = 1; detect_add = 0; write_enb_reg = 0; sts_clr = 0; addr_in = '0;
        read_enb = '0; empty = 8'($urandom); full = 8'($urandom);
        step(); step();
        compared++;
        if ({we_a, err_a, sr_a, sts_a} !== 10'b0) begin
            mismatched++; $display("FAIL reset_a_zero: got %b want 0", {we_a, err_a, sr_a, sts_a});
        end
        compared++;
        if (ff_a !== full[0] || vld_a !== ~empty[2:0]) begin
            mismatched++; $display("FAIL reset_a_comb: got ff=%b vld=%b want ff=%b vld=%b", ff_a, vld_a, full[0], ~empty[2:0]);
        end
        compared++;
        if ({we_b, err_b, sr_b, sts_b} !== 25'b0 || vld_b !== ~empty || ff_b !== full[0]) begin
            mismatched++; $display("FAIL reset_b: got we=%b err=%b sr=%b sts=%b", we_b, err_b, sr_b, sts_b);
        end
        reset = 0;
    endtask

    task automatic test_steering();
        idle();
        detect_add = 1; addr_in = 3'd2; full = 8'b100;
        step();
        detect_add = 0; write_enb_reg = 1; #1;
        compared++;
        if (we_a !== 3'b100 || ff_a !== 1'b1 || we_b !== 8'b100 || ff_b !== 1'b1) begin
            mismatched++; $display("FAIL steer_dest2: got we_a=%b ff_a=%b we_b=%b ff_b=%b want 100/1/00000100/1", we_a, ff_a, we_b, ff_b);
        end
        detect_add = 1; addr_in = 3'd1; #1;
        compared++;
        if (we_a !== 3'b100 || we_b !== 8'b100) begin
            mismatched++; $display("FAIL steer_old_dest: got we_a=%b we_b=%b want 100/00000100", we_a, we_b);
        end
        step();
        detect_add = 0; #1;
        compared++;
        if (we_a !== 3'b010 || ff_a !== 1'b0 || we_b !== 8'b10) begin
            mismatched++; $display("FAIL steer_dest1: got we_a=%b ff_a=%b we_b=%b want 010/0/00000010", we_a, ff_a, we_b);
        end
        detect_add = 1; addr_in = 3'd6; full = 8'b0100_0000;
        step();
        detect_add = 0; #1;
        compared++;
        if (we_a !== 3'b100 || ff_a !== 1'b0 || we_b !== 8'b0100_0000 || ff_b !== 1'b1) begin
            mismatched++; $display("FAIL steer_dest6: got we_a=%b ff_a=%b we_b=%b ff_b=%b", we_a, ff_a, we_b, ff_b);
        end
        for (int k = 0; k < 2; k++) begin
            compared++;
            if (act_vec(k) !== exp_vec(k)) begin
                mismatched++; $display("FAIL steer_model%0d: got %h want %h", k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_invalid();
        idle();
        detect_add = 1; addr_in = 3'd3;
        step();
        detect_add = 0; write_enb_reg = 1; full = 8'hff; #1;
        compared++;
        if (err_a !== 1'b1 || we_a !== 3'b000 || ff_a !== 1'b0) begin
            mismatched++; $display("FAIL invalid_a: got err=%b we=%b ff=%b want 1/000/0", err_a, we_a, ff_a);
        end
        compared++;
        if (err_b !== 1'b0 || we_b !== 8'b1000 || ff_b !== 1'b1) begin
            mismatched++; $display("FAIL invalid_b_ok: got err=%b we=%b ff=%b want 0/00001000/1", err_b, we_b, ff_b);
        end
    endtask

    task automatic test_timeout();
        int pulses_a, pulses_b, first, second;
        idle();
        pulses_a = 0; pulses_b = 0; first = 0; second = 0;
        empty[1] = 0;
        for (int n = 1; n <= 65; n++) begin
            step();
            if (sr_a[1]) begin
                pulses_a++;
                if (first == 0) first = n; else if (second == 0) second = n;
            end
            if (sr_b[1]) pulses_b++;
            for (int k = 0; k < 2; k++) begin
                compared++;
                if (act_vec(k) !== exp_vec(k)) begin
                    mismatched++; $display("FAIL timeout_model%0d step %0d: got %h want %h", k, n, act_vec(k), exp_vec(k));
                end
            end
        end
        compared++;
        if (first !== 30 || second !== 60 || pulses_a !== 2 || sts_a !== 3'b010) begin
            mismatched++; $display("FAIL timeout_a: got first=%0d second=%0d pulses=%0d sts=%b want 30/60/2/010", first, second, pulses_a, sts_a);
        end
        compared++;
        if (pulses_b !== 13 || sts_b !== 8'b10) begin
            mismatched++; $display("FAIL timeout_b: got pulses=%0d sts=%b want 13/00000010", pulses_b, sts_b);
        end
    endtask

    task automatic test_interrupt();
        int early, first;
        idle();
        early = 0; first = 0;
        empty[0] = 0;
        for (int n = 1; n <= 29; n++) begin
            step();
            if (sr_a[0]) early++;
        end
        read_enb[0] = 1;
        step();
        if (sr_a[0]) early++;
        read_enb[0] = 0;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (sr_a[0] && first == 0) first = n;
        end
        compared++;
        if (early !== 0 || first !== 30) begin
            mismatched++; $display("FAIL interrupt_a: got early=%0d first=%0d want 0/30", early, first);
        end
        compared++;
        if (act_vec(1) !== exp_vec(1)) begin
            mismatched++; $display("FAIL interrupt_model1: got %h want %h", act_vec(1), exp_vec(1));
        end
    endtask

    task automatic test_clear_set();
        idle();
        empty[2] = 0;
        for (int n = 1; n <= 29; n++) step();
        sts_clr = 1;
        step();
        compared++;
        if (sr_a[2] !== 1'b1 || sts_a[2] !== 1'b1) begin
            mismatched++; $display("FAIL clr_vs_set: got sr=%b sts=%b want 1/1", sr_a[2], sts_a[2]);
        end
        empty = 8'hff;
        step();
        sts_clr = 0;
        compared++;
        if (sr_a[2] !== 1'b0 || sts_a[2] !== 1'b0 || sts_b !== 8'b0) begin
            mismatched++; $display("FAIL clr_after: got sr=%b sts_a=%b sts_b=%b want 0/0/0", sr_a[2], sts_a[2], sts_b);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        idle();
        pulses = 0;
        detect_add = 1; addr_in = 3'd1;
        step();
        detect_add = 0;
        empty[0] = 0;
        for (int n = 1; n <= 19; n++) step();
        reset = 1;
        step();
        reset = 0;
        compared++;
        if ({sr_a, sts_a, err_a, we_a} !== 10'b0 || {sr_b, sts_b, err_b, we_b} !== 25'b0) begin
            mismatched++; $display("FAIL reset_mid: got a=%b b=%b want 0", {sr_a, sts_a, err_a, we_a}, {sr_b, sts_b, err_b, we_b});
        end
        for (int n = 1; n <= 15; n++) begin
            step();
            if (sr_a[0]) pulses++;
            compared++;
            if (act_vec(1) !== exp_vec(1)) begin
                mismatched++; $display("FAIL reset_mid_model1 step %0d: got %h want %h", n, act_vec(1), exp_vec(1));
            end
        end
        compared++;
        if (pulses !== 0) begin
            mismatched++; $display("FAIL reset_mid_nopulse: got %0d pulses want 0", pulses);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 199) == 0);
            detect_add    = ($urandom_range(0, 3) == 0);
            addr_in       = 3'($urandom);
            write_enb_reg = 1'($urandom);
            full          = 8'($urandom);
            sts_clr       = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 8; c++) begin
                read_enb[c] = ($urandom_range(0, 31) == 0);
                empty[c]    = ($urandom_range(0, 31) == 0);
            end
            step();
            for (int k = 0; k < 2; k++) begin
                compared++;
                if (act_vec(k) !== exp_vec(k)) begin
                    mismatched++; $display("FAIL random_model%0d cycle %0d: got %h want %h", k, n, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        reset = 1; detect_add = 0; write_enb_reg = 0; sts_clr = 0;
        addr_in = '0; read_enb = '0; empty = 8'hff; full = '0;
        test_reset();
        test_steering();
        test_invalid();
        test_timeout();
        test_interrupt();
        test_clear_set();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/router_sync_param.md
# router_sync_param

Parametrised successor to the 3-port router synchroniser. It latches the destination address of each packet and steers FIFO write enables to the addressed output channel. It also reports that channel's full status, generates valid-out from FIFO empty flags, and issues per-channel soft resets when an output is left unread for a programmable number of cycles. It sits between the router FSM/register block and the NUM_CH output FIFOs, and adds an invalid-address flag and sticky timeout status.

## Interface
Parameters:
- NUM_CH, 3: number of output channels/FIFOs (2..8).
- ADDR_W, 2: destination address width; must satisfy 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30: consecutive stalled cycles before soft reset (2..255).
- CNT_W, 5: timeout counter width; must satisfy 2**CNT_W > TIMEOUT-1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  header byte present; load destination.
- write_enb_reg  in  1  FSM write request for current packet.
- addr_in  in  ADDR_W  destination address (header bits).
- read_enb  in  NUM_CH  per-channel read enable from downstream.
- empty  in  NUM_CH  per-FIFO empty flags.
- full  in  NUM_CH  per-FIFO full flags.
- sts_clr  in  1  clears all timeout_sts bits.
- vld_out  out  NUM_CH  per-channel valid.
- write_enb  out  NUM_CH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the addressed FIFO.
- soft_reset  out  NUM_CH  one-cycle soft-reset pulse per FIFO.
- addr_err  out  1  latched destination is not a valid channel.
- timeout_sts  out  NUM_CH  sticky record of soft-reset events.

## Operation
- Destination register `dest` (ADDR_W bits): reset to 0. Loads addr_in at a clock edge where detect_add=1; otherwise holds.
- dest_ok = (dest < NUM_CH). addr_err = !dest_ok, combinational from dest.
- write_enb = (write_enb_reg && dest_ok) ? one-hot(dest) : 0. Never more than one bit set.
- fifo_full = dest_ok ? full[dest] : 0.
- vld_out[i] = !empty[i], combinational.
- Per-channel timer i, with cnt[i] (CNT_W bits):
  - reset: cnt=0, soft_reset=0.
  - vld_out[i] && !read_enb[i] (stall):
    - if cnt==TIMEOUT-1: soft_reset[i]=1, cnt=0.
    - otherwise: cnt+=1, soft_reset[i]=0.
  - any other cycle: cnt=0, soft_reset[i]=0.
- timeout_sts[i]: reset 0. Set on the edge where soft_reset[i] is loaded with 1. Cleared by sts_clr. A set and sts_clr in the same cycle leaves the bit set.
- Channels are fully independent. Simultaneous timeouts on several channels all pulse in the same cycle.

## Timing
- Reset values: dest=0, all cnt=0, soft_reset=0, timeout_sts=0.
- Combinational outputs after reset: addr_err=0, write_enb=0, fifo_full=full[0], vld_out=~empty.
- dest latency is one cycle. If detect_add and write_enb_reg are high in the same cycle, write_enb uses the old dest.
- write_enb, fifo_full and addr_err follow dest and their inputs with zero-cycle latency.
- soft_reset[i] goes high in the cycle after the TIMEOUT-th consecutive stalled edge, and lasts exactly one cycle.
- If the stall persists after a pulse, the next pulse comes TIMEOUT cycles later.
- Any read_enb[i]=1 or empty[i]=1 cycle restarts the count from 0.
- Counter wrap cannot occur: cnt never exceeds TIMEOUT-1.
- reset asserted mid-count clears cnt and soft_reset on that edge. No pulse is produced.

## Structure
- Package router_pkg holds:
  - default constants ROUTER_NUM_CH=3, ROUTER_ADDR_W=2, ROUTER_TIMEOUT=30;
  - a function computing CNT_W from TIMEOUT.
- One sub-module, router_sync_timer: per-channel counter, soft_reset and timeout_sts bit. It takes parameters TIMEOUT and CNT_W and is instantiated NUM_CH times via a generate loop.
- Top level holds the dest register, write-enable decode and full mux.

## Test plan
- Address steering: reset, detect_add with addr_in=2, then write_enb_reg=1 → write_enb=3'b100 from the next cycle. With full=3'b100, fifo_full=1.
- Invalid address: NUM_CH=3, addr_in=3 with detect_add → addr_err=1, write_enb=0, fifo_full=0 despite write_enb_reg=1 and full=3'b111.
- Timeout: empty[1]=0, read_enb[1]=0 held → soft_reset[1] high for exactly one cycle after 30 stalled edges, and timeout_sts[1]=1. Holding the stall gives a second pulse 30 cycles later.
- Stall interrupted: stall channel 0 for 29 cycles, read_enb[0]=1 for one cycle, stall again → first pulse only after 30 further stalled cycles.
- Clear versus set: sts_clr asserted on the same edge a pulse sets timeout_sts[2] → bit remains 1. sts_clr on the next edge → bit becomes 0.
- Reset mid-operation and scaling: reset at count 20 → no pulse, and all outputs return to reset values. Rerun the steering and timeout tests with NUM_CH=8, ADDR_W=3, TIMEOUT=5.
